// File: rtl/seg_tx_pkg.sv
// Shared definitions for the seven-segment serial transmitter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package seg_tx_pkg;

  // FSM state encoding; values are fixed so they read the same in any dump.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_SHIFT = 2'd2,
    ST_LATCH = 2'd3
  } state_t;

  // Default frame width and serial-clock half-period (in clk cycles).
  localparam int SEG_DATA_W = 64;
  localparam int SEG_HALF   = 2;

endpackage

// File: rtl/seg_shift_tx_if.sv
// Frame request and pin-side bundle between the segment mapper and the serial transmitter.
// Latency: n/a (wires only).
// Backpressure: none; start is level-sampled only while the transmitter is idle.
interface seg_shift_tx_if
  import seg_tx_pkg::*;
#(
  parameter int DATA_W = SEG_DATA_W
) ();

  logic              start;
  logic [DATA_W-1:0] pdata;
  logic              busy;
  logic              done;
  logic              sclk;
  logic              sdata;
  logic              sclr_n;
  logic              latch;

  // Mapper side: issues frames, observes status and pins.
  modport master (
    output start,
    output pdata,
    input  busy,
    input  done,
    input  sclk,
    input  sdata,
    input  sclr_n,
    input  latch
  );

  // Transmitter side.
  modport slave (
    input  start,
    input  pdata,
    output busy,
    output done,
    output sclk,
    output sdata,
    output sclr_n,
    output latch
  );

endinterface

// File: rtl/seg_tx_tick.sv
// Half-period timer: one-cycle o_phase_end strobe on every HALF-th cycle since restart.
// Latency: strobe in the HALF-th cycle after i_restart (counter reads 0 the cycle after restart).
// Backpressure: none; free-running between restarts.
module seg_tx_tick
  import seg_tx_pkg::*;
#(
  parameter int HALF = SEG_HALF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_restart,
  output logic o_phase_end
);

  localparam int CNT_W = $clog2(HALF + 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_phase_end = (r_cnt == CNT_W'(HALF - 1));

  // Count 0..HALF-1 and wrap; a restart realigns the count to the new phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_restart || o_phase_end) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seg_shift_tx.sv
// Serial transmitter for the seven-segment shift-register chain: clear, shift DATA_W bits MSB-first, latch.
// Latency: done pulses 2*HALF*(DATA_W+1)+1 cycles after start is sampled; all pin outputs are registered.
// Backpressure: start ignored while busy (no queueing); start in the done cycle is accepted.
// Optional feature macro: SEG_TX_AUTO_REFRESH_EN (self-start on pdata change or after REFRESH_CYCLES idle).
module seg_shift_tx
  import seg_tx_pkg::*;
#(
  parameter int DATA_W = SEG_DATA_W,
  parameter int HALF   = SEG_HALF
`ifdef SEG_TX_AUTO_REFRESH_EN
  ,
  parameter int REFRESH_CYCLES = 1_000_000
`endif
) (
  input  logic          clk,
  input  logic          rst_n,
  seg_shift_tx_if.slave bus
);

  localparam int BIT_W = $clog2(DATA_W + 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_shreg;
  logic [DATA_W-1:0] w_shl;
  logic [BIT_W-1:0]  r_bit;
  logic              r_hi;
  logic              w_hi_nxt;
  logic              w_capture;
  logic              w_shift;
  logic              w_sdata_nxt;
  logic              w_done_nxt;
  logic              w_go;
  logic              w_phase_end;
  logic              w_restart;

  logic              r_busy;
  logic              r_done;
  logic              r_sclk;
  logic              r_sdata;
  logic              r_sclr_n;
  logic              r_latch;

  assign w_shl     = r_shreg << 1;
  assign w_restart = (w_state_nxt != r_state);

  seg_tx_tick #(
    .HALF (HALF)
  ) u_tick (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_restart   (w_restart),
    .o_phase_end (w_phase_end)
  );

`ifdef SEG_TX_AUTO_REFRESH_EN
  localparam int REF_W = $clog2(REFRESH_CYCLES + 1);

  logic [DATA_W-1:0] r_last;
  logic [REF_W-1:0]  r_idle_cnt;
  logic              w_refresh_hit;

  assign w_refresh_hit = (r_idle_cnt == REF_W'(REFRESH_CYCLES - 1));
  // Self-start and external start merge into one request, so both together give one frame.
  assign w_go = bus.start || (bus.pdata != r_last) || w_refresh_hit;

  // Remember the last frame sent and count consecutive idle cycles since it finished.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last     <= '0;
      r_idle_cnt <= '0;
    end else begin
      if (w_capture) begin
        r_last <= bus.pdata;
      end
      if (r_state != ST_IDLE || w_capture) begin
        r_idle_cnt <= '0;
      end else begin
        r_idle_cnt <= r_idle_cnt + 1'b1;
      end
    end
  end
`else
  assign w_go = bus.start;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and datapath controls; phase boundaries come from the tick strobe.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_shift     = 1'b0;
    w_hi_nxt    = r_hi;
    w_sdata_nxt = r_sdata;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_go) begin
          w_state_nxt = ST_CLEAR;
          w_capture   = 1'b1;
        end
      end
      ST_CLEAR: begin
        if (w_phase_end) begin
          w_state_nxt = ST_SHIFT;
          w_hi_nxt    = 1'b0;
          w_sdata_nxt = r_shreg[DATA_W-1];
        end
      end
      ST_SHIFT: begin
        if (w_phase_end) begin
          if (!r_hi) begin
            w_hi_nxt = 1'b1;
          end else begin
            w_shift  = 1'b1;
            w_hi_nxt = 1'b0;
            if (r_bit == BIT_W'(DATA_W - 1)) begin
              w_state_nxt = ST_LATCH;
              w_sdata_nxt = 1'b0;
            end else begin
              // Data changes only at the start of a low phase, half a period before the chain samples it.
              w_sdata_nxt = w_shl[DATA_W-1];
            end
          end
        end
      end
      ST_LATCH: begin
        if (w_phase_end) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Shift register, bit counter and serial-clock phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg <= '0;
      r_bit   <= '0;
      r_hi    <= 1'b0;
    end else begin
      r_hi <= w_hi_nxt;
      if (w_capture) begin
        r_shreg <= bus.pdata;
        r_bit   <= '0;
      end else if (w_shift) begin
        r_shreg <= w_shl;
        r_bit   <= r_bit + 1'b1;
      end
    end
  end

  // Pin outputs are decoded from the next state and registered so the board sees glitch-free levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_sclk   <= 1'b0;
      r_sdata  <= 1'b0;
      r_sclr_n <= 1'b1;
      r_latch  <= 1'b0;
    end else begin
      r_busy   <= (w_state_nxt != ST_IDLE);
      r_done   <= w_done_nxt;
      r_sclk   <= (w_state_nxt == ST_SHIFT) && w_hi_nxt;
      r_sdata  <= w_sdata_nxt;
      r_sclr_n <= (w_state_nxt != ST_CLEAR);
      r_latch  <= (w_state_nxt == ST_LATCH);
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.sclk   = r_sclk;
  assign bus.sdata  = r_sdata;
  assign bus.sclr_n = r_sclr_n;
  assign bus.latch  = r_latch;

endmodule
